// File: rtl/sobel_window_engine_if.sv
// Column-beat bus between the line-buffer chain and the Sobel window engine.
// The master drives the three-row column beat; the slave returns the edge pixel stream.
`timescale 1ns/1ps
interface sobel_window_engine_if;
    logic       valid_i;
    logic [7:0] row0_i;
    logic [7:0] row1_i;
    logic [7:0] row2_i;
    logic       valid_o;
    logic [7:0] pix_o;
    logic       eol_o;

    modport master (
        output valid_i, row0_i, row1_i, row2_i,
        input  valid_o, pix_o, eol_o
    );

    modport slave (
        input  valid_i, row0_i, row1_i, row2_i,
        output valid_o, pix_o, eol_o
    );
endinterface

// File: rtl/sobel_window_engine.sv
// Sliding 3x3 Sobel engine: window/column tracking, gradients, magnitude in three registered stages.
// Optional macro SOBEL_THRESHOLD_EN binarises the magnitude against THRESH instead of saturating it.
`timescale 1ns/1ps
module sobel_window_engine #(
    parameter int WIDTH  = 170,
    parameter int THRESH = 100
) (
    input logic                  clk,
    input logic                  rst,
    sobel_window_engine_if.slave bus
);
    localparam logic [9:0] COL_LAST = 10'(WIDTH - 1);

    logic [9:0]         col_reg;
    logic [7:0]         win_reg [3][3];
    logic [7:0]         row_in  [3];
    logic               s1_v_reg;
    logic               s1_eol_reg;
    logic [9:0]         col_sum [2];
    logic [9:0]         row_sum [2];
    logic signed [10:0] gx_next;
    logic signed [10:0] gy_next;
    logic signed [10:0] gx_reg;
    logic signed [10:0] gy_reg;
    logic               s2_v_reg;
    logic               s2_eol_reg;
    logic [10:0]        abs_x;
    logic [10:0]        abs_y;
    logic [10:0]        mag;
    logic [7:0]         pix_next;

    // Out-of-range parameters surface as this named scope in the elaborated hierarchy.
    if (WIDTH < 3 || WIDTH > 1023 || THRESH < 0) begin : g_illegal_params
    end

    assign row_in = '{bus.row0_i, bus.row1_i, bus.row2_i};

    // Stage 1: column position, window shift and the valid/eol tags for the new window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_reg    <= '0;
            s1_v_reg   <= 1'b0;
            s1_eol_reg <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_reg[r][c] <= '0;
                end
            end
        end else begin
            s1_v_reg   <= bus.valid_i && (col_reg >= 10'd2);
            s1_eol_reg <= bus.valid_i && (col_reg == COL_LAST);
            if (bus.valid_i) begin
                col_reg <= (col_reg == COL_LAST) ? 10'd0 : col_reg + 10'd1;
                for (int r = 0; r < 3; r++) begin
                    win_reg[r][0] <= win_reg[r][1];
                    win_reg[r][1] <= win_reg[r][2];
                    win_reg[r][2] <= row_in[r];
                end
            end
        end
    end

    // Index 0 is the left column / top row, index 1 the right column / bottom row, weights 1-2-1.
    for (genvar gi = 0; gi < 2; gi++) begin : g_edge_sum
        localparam int K = 2 * gi;
        assign col_sum[gi] = {2'b00, win_reg[0][K]} + {1'b0, win_reg[1][K], 1'b0} + {2'b00, win_reg[2][K]};
        assign row_sum[gi] = {2'b00, win_reg[K][0]} + {1'b0, win_reg[K][1], 1'b0} + {2'b00, win_reg[K][2]};
    end

    assign gx_next = $signed({1'b0, col_sum[1]}) - $signed({1'b0, col_sum[0]});
    assign gy_next = $signed({1'b0, row_sum[1]}) - $signed({1'b0, row_sum[0]});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gx_reg     <= '0;
            gy_reg     <= '0;
            s2_v_reg   <= 1'b0;
            s2_eol_reg <= 1'b0;
        end else begin
            gx_reg     <= gx_next;
            gy_reg     <= gy_next;
            s2_v_reg   <= s1_v_reg;
            s2_eol_reg <= s1_eol_reg;
        end
    end

    assign abs_x = gx_reg[10] ? $unsigned(-gx_reg) : $unsigned(gx_reg);
    assign abs_y = gy_reg[10] ? $unsigned(-gy_reg) : $unsigned(gy_reg);
    assign mag   = abs_x + abs_y;

`ifdef SOBEL_THRESHOLD_EN
    assign pix_next = (mag >= 11'(THRESH)) ? 8'd255 : 8'd0;
`else
    assign pix_next = (mag > 11'd255) ? 8'd255 : mag[7:0];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.valid_o <= 1'b0;
            bus.pix_o   <= '0;
            bus.eol_o   <= 1'b0;
        end else begin
            bus.valid_o <= s2_v_reg;
            bus.pix_o   <= pix_next;
            bus.eol_o   <= s2_eol_reg;
        end
    end
endmodule

// File: tb/tb_sobel_window_engine.sv
// Self-checking bench for sobel_window_engine: directed images plus randomized lines and gaps,
// compared against a whole-image Sobel reference computed with plain integer arithmetic.
`timescale 1ns/1ps
module tb_sobel_window_engine;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sobel_window_engine_if bus();

    sobel_window_engine #(.WIDTH(W), .THRESH(100)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int passes = 0;
    int edge_n = 0;
    int stray_eol = 0;
    int img [3][W];
    int exp_pix[$], exp_eol[$], exp_edge[$];
    int obs_pix[$], obs_eol[$], obs_edge[$];

    // Reference output for the window centred on column c of the current image line.
    function automatic int sobel_ref(int c);
        int gx, gy, mag;
        gx  = (img[0][c+1] + 2 * img[1][c+1] + img[2][c+1]) - (img[0][c-1] + 2 * img[1][c-1] + img[2][c-1]);
        gy  = (img[2][c-1] + 2 * img[2][c] + img[2][c+1]) - (img[0][c-1] + 2 * img[0][c] + img[0][c+1]);
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
`ifdef SOBEL_THRESHOLD_EN
        return (mag >= 100) ? 255 : 0;
`else
        return (mag > 255) ? 255 : mag;
`endif
    endfunction

    task automatic step(input bit v, input int a, input int b, input int c);
        bus.valid_i = v;
        bus.row0_i  = 8'(a);
        bus.row1_i  = 8'(b);
        bus.row2_i  = 8'(c);
        @(posedge clk);
        edge_n++;
        #1;
        if (bus.valid_o === 1'b1) begin
            obs_pix.push_back(int'(bus.pix_o));
            obs_eol.push_back(int'(bus.eol_o));
            obs_edge.push_back(edge_n);
        end else if (bus.eol_o !== 1'b0) begin
            stray_eol++;
        end
    endtask

    task automatic idle_step();
        step(1'b0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    endtask

    // gap_mode: 0 back-to-back, 1 one idle cycle between beats, 2 random 0..2 idle cycles.
    task automatic send_line(input int gap_mode);
        for (int c = 0; c < W; c++) begin
            if (gap_mode == 1 && c > 0) idle_step();
            if (gap_mode == 2) repeat ($urandom_range(0, 2)) idle_step();
            step(1'b1, img[0][c], img[1][c], img[2][c]);
            if (c >= 2) begin
                exp_pix.push_back(sobel_ref(c - 1));
                exp_eol.push_back((c == W - 1) ? 1 : 0);
                exp_edge.push_back(edge_n + 2);
            end
        end
    endtask

    task automatic clear_queues();
        exp_pix.delete(); exp_eol.delete(); exp_edge.delete();
        obs_pix.delete(); obs_eol.delete(); obs_edge.delete();
    endtask

    task automatic random_image();
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = int'($urandom_range(0, 255));
    endtask

    task automatic test_reset();
        bus.valid_i = 1'b0;
        bus.row0_i = '0; bus.row1_i = '0; bus.row2_i = '0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.valid_o !== 1'b0) $display("FAIL reset_valid: got %b expected 0", bus.valid_o); else passes++;
        checks++; if (bus.pix_o !== 8'd0) $display("FAIL reset_pix: got %0d expected 0", bus.pix_o); else passes++;
        checks++; if (bus.eol_o !== 1'b0) $display("FAIL reset_eol: got %b expected 0", bus.eol_o); else passes++;
        rst = 1'b1;
        clear_queues();
        repeat (4) idle_step();
        checks++; if (obs_pix.size() !== 0) $display("FAIL reset_idle_outputs: got %0d outputs expected 0", obs_pix.size()); else passes++;
    endtask

    task automatic test_flat();
        clear_queues();
        for (int r = 0; r < 3; r++) for (int c = 0; c < W; c++) img[r][c] = 128;
        send_line(0);
        repeat (4) idle_step();
        checks++; if (obs_pix.size() !== 6) $display("FAIL flat_count: got %0d outputs expected 6", obs_pix.size()); else passes++;
        for (int i = 0; i < exp_pix.size() && i < obs_pix.size(); i++) begin
            checks++; if (obs_pix[i] !== 0) $display("FAIL flat_pix[%0d]: got %0d expected 0", i, obs_pix[i]); else passes++;
            checks++; if (obs_eol[i] !== exp_eol[i]) $display("FAIL flat_eol[%0d]: got %0d expected %0d", i, obs_eol[i], exp_eol[i]); else passes++;
            checks++; if (obs_edge[i] !== exp_edge[i]) $display("FAIL flat_time[%0d]: got edge %0d expected %0d", i, obs_edge[i], exp_edge[i]); else passes++;
        end
    endtask

    task automatic test_ramp();
        int ramp_pix;
`ifdef SOBEL_THRESHOLD_EN
        ramp_pix = 0;
`else
        ramp_pix = 8;
`endif
        clear_queues();
        for (int r = 0; r < 3; r++) for (int c = 0; c < W; c++) img[r][c] = c;
        send_line(0);
        repeat (4) idle_step();
        checks++; if (obs_pix.size() !== exp_pix.size()) $display("FAIL ramp_count: got %0d outputs expected %0d", obs_pix.size(), exp_pix.size()); else passes++;
        for (int i = 0; i < exp_pix.size() && i < obs_pix.size(); i++) begin
            checks++; if (obs_pix[i] !== ramp_pix) $display("FAIL ramp_pix[%0d]: got %0d expected %0d", i, obs_pix[i], ramp_pix); else passes++;
            checks++; if (obs_eol[i] !== exp_eol[i]) $display("FAIL ramp_eol[%0d]: got %0d expected %0d", i, obs_eol[i], exp_eol[i]); else passes++;
            checks++; if (obs_edge[i] !== exp_edge[i]) $display("FAIL ramp_time[%0d]: got edge %0d expected %0d", i, obs_edge[i], exp_edge[i]); else passes++;
        end
    endtask

    task automatic test_step_edge();
        clear_queues();
        for (int r = 0; r < 3; r++) for (int c = 0; c < W; c++) img[r][c] = (c >= 4) ? 255 : 0;
        send_line(0);
        repeat (4) idle_step();
        checks++; if (obs_pix.size() !== 6) $display("FAIL step_count: got %0d outputs expected 6", obs_pix.size()); else passes++;
        for (int i = 0; i < 6 && i < obs_pix.size(); i++) begin
            // Output i is the window centred on column i+1; only centres 3 and 4 straddle the edge.
            checks++;
            if (obs_pix[i] !== ((i == 2 || i == 3) ? 255 : 0))
                $display("FAIL step_pix[%0d]: got %0d expected %0d", i, obs_pix[i], (i == 2 || i == 3) ? 255 : 0);
            else passes++;
            checks++; if (obs_edge[i] !== exp_edge[i]) $display("FAIL step_time[%0d]: got edge %0d expected %0d", i, obs_edge[i], exp_edge[i]); else passes++;
        end
    endtask

    task automatic test_gapped();
        clear_queues();
        for (int r = 0; r < 3; r++) for (int c = 0; c < W; c++) img[r][c] = c;
        send_line(1);
        repeat (4) idle_step();
        checks++; if (obs_pix.size() !== exp_pix.size()) $display("FAIL gap_count: got %0d outputs expected %0d", obs_pix.size(), exp_pix.size()); else passes++;
        for (int i = 0; i < exp_pix.size() && i < obs_pix.size(); i++) begin
            checks++; if (obs_pix[i] !== exp_pix[i]) $display("FAIL gap_pix[%0d]: got %0d expected %0d", i, obs_pix[i], exp_pix[i]); else passes++;
            checks++; if (obs_eol[i] !== exp_eol[i]) $display("FAIL gap_eol[%0d]: got %0d expected %0d", i, obs_eol[i], exp_eol[i]); else passes++;
            checks++; if (obs_edge[i] !== exp_edge[i]) $display("FAIL gap_time[%0d]: got edge %0d expected %0d", i, obs_edge[i], exp_edge[i]); else passes++;
        end
    endtask

    task automatic test_mid_line_reset();
        clear_queues();
        random_image();
        for (int c = 0; c < 4; c++) step(1'b1, img[0][c], img[1][c], img[2][c]);
        bus.valid_i = 1'b0;
        rst = 1'b0;
        #1;
        checks++; if (bus.valid_o !== 1'b0 || bus.pix_o !== 8'd0 || bus.eol_o !== 1'b0)
            $display("FAIL midreset_async: got valid=%b pix=%0d eol=%b expected 0/0/0", bus.valid_o, bus.pix_o, bus.eol_o);
        else passes++;
        repeat (2) begin
            @(posedge clk);
            edge_n++;
            #1;
            checks++; if (bus.valid_o !== 1'b0 || bus.pix_o !== 8'd0 || bus.eol_o !== 1'b0)
                $display("FAIL midreset_hold: got valid=%b pix=%0d eol=%b expected 0/0/0", bus.valid_o, bus.pix_o, bus.eol_o);
            else passes++;
        end
        rst = 1'b1;
        random_image();
        send_line(0);
        repeat (4) idle_step();
        checks++; if (obs_pix.size() !== 6) $display("FAIL midreset_count: got %0d outputs expected 6", obs_pix.size()); else passes++;
        for (int i = 0; i < exp_pix.size() && i < obs_pix.size(); i++) begin
            checks++; if (obs_pix[i] !== exp_pix[i]) $display("FAIL midreset_pix[%0d]: got %0d expected %0d", i, obs_pix[i], exp_pix[i]); else passes++;
            checks++; if (obs_edge[i] !== exp_edge[i]) $display("FAIL midreset_time[%0d]: got edge %0d expected %0d", i, obs_edge[i], exp_edge[i]); else passes++;
        end
    endtask

    task automatic test_back_to_back();
        clear_queues();
        for (int l = 0; l < 3; l++) begin
            random_image();
            send_line(0);
        end
        repeat (4) idle_step();
        checks++; if (obs_pix.size() !== 18) $display("FAIL b2b_count: got %0d outputs expected 18", obs_pix.size()); else passes++;
        for (int i = 0; i < exp_pix.size() && i < obs_pix.size(); i++) begin
            checks++; if (obs_pix[i] !== exp_pix[i]) $display("FAIL b2b_pix[%0d]: got %0d expected %0d", i, obs_pix[i], exp_pix[i]); else passes++;
            checks++; if (obs_eol[i] !== exp_eol[i]) $display("FAIL b2b_eol[%0d]: got %0d expected %0d", i, obs_eol[i], exp_eol[i]); else passes++;
            checks++; if (obs_edge[i] !== exp_edge[i]) $display("FAIL b2b_time[%0d]: got edge %0d expected %0d", i, obs_edge[i], exp_edge[i]); else passes++;
        end
    endtask

    task automatic test_random_gaps();
        clear_queues();
        for (int l = 0; l < 4; l++) begin
            random_image();
            send_line(2);
        end
        repeat (4) idle_step();
        checks++; if (obs_pix.size() !== exp_pix.size()) $display("FAIL rgap_count: got %0d outputs expected %0d", obs_pix.size(), exp_pix.size()); else passes++;
        for (int i = 0; i < exp_pix.size() && i < obs_pix.size(); i++) begin
            checks++; if (obs_pix[i] !== exp_pix[i]) $display("FAIL rgap_pix[%0d]: got %0d expected %0d", i, obs_pix[i], exp_pix[i]); else passes++;
            checks++; if (obs_eol[i] !== exp_eol[i]) $display("FAIL rgap_eol[%0d]: got %0d expected %0d", i, obs_eol[i], exp_eol[i]); else passes++;
            checks++; if (obs_edge[i] !== exp_edge[i]) $display("FAIL rgap_time[%0d]: got edge %0d expected %0d", i, obs_edge[i], exp_edge[i]); else passes++;
        end
        checks++; if (stray_eol !== 0) $display("FAIL stray_eol: got %0d eol pulses without valid expected 0", stray_eol); else passes++;
    endtask

    initial begin
        test_reset();
        test_flat();
        test_ramp();
        test_step_edge();
        test_gapped();
        test_mid_line_reset();
        test_back_to_back();
        test_random_gaps();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/sobel_window_engine.md
# sobel_window_engine

Downstream consumer of the three-row line-buffer chain. Each accepted beat delivers one column of three vertically aligned pixels (top, middle, bottom). The block assembles a sliding 3x3 window, computes horizontal and vertical Sobel gradients, and emits a saturated 8-bit edge magnitude through a fixed three-stage pipeline. It sits between the line buffers and the output pixel writer.

## Interface
- `WIDTH`, 170: pixels per image line; must equal the line-buffer `DEPTH`; legal range 3..1023.
- `THRESH`, 100: binarisation threshold, used only when `SOBEL_THRESHOLD_EN` is defined.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `valid_i`  in  1  column beat valid; no backpressure, the block always accepts.
- `row0_i`  in  8  top-row pixel (oldest line).
- `row1_i`  in  8  middle-row pixel.
- `row2_i`  in  8  bottom-row pixel (newest line).
- `valid_o`  out  1  `pix_o` valid this cycle.
- `pix_o`  out  8  edge magnitude, or binarised value.
- `eol_o`  out  1  qualifies the last output pixel of a line; only high while `valid_o` is high.

## Operation
- Column counter `col`, 10 bits, range 0..WIDTH-1.
  - Increments on each `valid_i`.
  - Wraps from WIDTH-1 to 0.
  - Unchanged when `valid_i` is low.
- Window: 3x3 register array `p[r][c]`, c=2 newest.
  - On `valid_i`: columns shift left (c1→c0, c2→c1) and the row inputs load into c2.
- Stage 1 valid: `s1_v = valid_i && col>=2`, sampled with the pre-increment `col`.
  - A line of WIDTH beats produces exactly WIDTH-2 outputs.
  - The window never spans two lines: the first two beats of each line only prime it.
- Stage 1 eol tag: `s1_eol = valid_i && col==WIDTH-1`.
- Stage 2 gradients, 11-bit signed:
  - `Gx = (p02+2p12+p22) − (p00+2p10+p20)`
  - `Gy = (p20+2p21+p22) − (p00+2p01+p02)`
  - Range ±1020, no overflow.
- Stage 3 magnitude: `|Gx|+|Gy|`, 11-bit unsigned, max 2040. `pix_o = min(mag,255)`.
- Valid and eol tags travel with the data through every stage.
- Gaps in `valid_i` insert bubbles. The pipeline still advances every cycle, so there is no stall state.
- Reset clears all of the following, asynchronously:
  - `col`
  - the window registers
  - the stage 2 and stage 3 data registers
  - all valid and eol flags
- Reset mid-line discards the partial line; the next beat is treated as column 0.

## Timing
- All outputs are registered. Reset values: `valid_o`=0, `pix_o`=0, `eol_o`=0.
- Latency is 3 rising edges:
  - A qualifying `valid_i` sampled at edge N produces `valid_o` high in the cycle after edge N+2.
- Throughput is one pixel per cycle. Back-to-back beats give back-to-back outputs.
- Between the last beat of one line and the first of the next:
  - `col` wraps with no idle cycle required.
  - `valid_o` is low for exactly 2 output slots (the priming beats).
- Reset deassertion is synchronised externally. The first beat may arrive on the first edge after release.

## Configuration
- `SOBEL_THRESHOLD_EN` defined:
  - stage 3 outputs `pix_o = (mag >= THRESH) ? 8'd255 : 8'd0`;
  - the compare uses the unsaturated 11-bit magnitude;
  - latency is unchanged.
- `SOBEL_THRESHOLD_EN` undefined:
  - `pix_o` is the saturated magnitude;
  - `THRESH` is unused and generates no logic.

## Test plan
- Flat image, all rows 0x80, WIDTH=8, 8 beats:
  - 6 outputs, all `pix_o`=0;
  - `eol_o` only on the 6th;
  - first `valid_o` 3 cycles after the 3rd beat.
- Horizontal ramp, pixel = column index in all rows, WIDTH=8:
  - `Gx`=8, `Gy`=0, every `pix_o`=8.
- Vertical step, columns 0–3 = 0 and columns 4–7 = 255, all rows, WIDTH=8:
  - outputs at window centres 3 and 4 are 255 (saturated from 1020);
  - all other outputs are 0.
- Gapped input: same ramp with `valid_i` low every other cycle:
  - identical 6 values;
  - each output exactly 3 cycles after its beat;
  - `valid_o` gaps mirror the input gaps.
- Reset pulse after the 4th beat of a line, then a fresh full line:
  - all outputs 0 during and after reset;
  - exactly 6 outputs for the new line, none from the old line.
- With `SOBEL_THRESHOLD_EN`, THRESH=100:
  - ramp gives all `pix_o`=0;
  - step gives 255 at window centres 3 and 4, 0 elsewhere.
